alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one registered ALU.
// One command in flight: IDLE -> ISSUE -> CAPTURE -> RESP, or IDLE -> RESP on divide-by-zero.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int FUN_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  async_rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [FUN_WIDTH-1:0]  req0_fun,
    input  logic [FUN_WIDTH-1:0]  req1_fun,
    output logic                  alu_en,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [FUN_WIDTH-1:0]  alu_fun,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_carry,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic [7:0]            op_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [FUN_WIDTH-1:0] FUN_DIV = FUN_WIDTH'(3);

    state_t                r_state;
    state_t                w_next;
    logic                  r_ptr;
    logic                  r_win;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [FUN_WIDTH-1:0]  r_fun;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_carry;
    logic                  r_err;
    logic [7:0]            r_count;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_sel;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [FUN_WIDTH-1:0]  w_fun;
    logic                  w_div0;
    logic                  w_rsp_hs;

    // r_ptr names the requester that wins when both are valid.
    always_comb begin
        w_grant = '0;
        if (r_state == S_IDLE) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = '0;
            endcase
        end
    end

    assign w_accept = |w_grant;
    assign w_sel    = w_grant[1];
    assign w_a      = w_sel ? req1_a   : req0_a;
    assign w_b      = w_sel ? req1_b   : req0_b;
    assign w_fun    = w_sel ? req1_fun : req0_fun;
    assign w_div0   = (w_fun == FUN_DIV) && (w_b == '0);
    assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_win];

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = w_div0 ? S_RESP : S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (w_rsp_hs) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_ptr   <= 1'b0;
            r_win   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_fun   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_fun <= w_fun;
                r_win <= w_sel;
                r_ptr <= ~w_sel;
                if (w_div0) begin
                    r_data  <= '1;
                    r_err   <= 1'b1;
                    r_carry <= 1'b0;
                end
            end
            if (r_state == S_ISSUE) r_carry <= alu_carry;
            if (r_state == S_CAPTURE) begin
                r_data <= alu_out;
                r_err  <= 1'b0;
            end
            if (w_rsp_hs) r_count <= r_count + 8'd1;
        end
    end

    // Grant is combinational from req_valid, so it is gated to honour all-zero outputs in reset.
    assign req_ready = async_rst ? w_grant : 2'b00;
    assign alu_en    = (r_state == S_ISSUE);
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_fun   = r_fun;
    assign rsp_valid = (r_state == S_RESP) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = r_data;
    assign rsp_carry = r_carry;
    assign rsp_err   = r_err;
    assign op_count  = r_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_fun = '0, req1_fun = '0;
    logic        alu_en;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_fun;
    logic [15:0] alu_out = '0;
    logic        alu_carry;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [15:0] rsp_data;
    logic        rsp_carry, rsp_err;
    logic [7:0]  op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(16), .FUN_WIDTH(2)) dut (
        .clk(clk), .async_rst(async_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fun(req0_fun), .req1_fun(req1_fun),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // ALU model: registered result, combinational carry/borrow.
    logic [16:0] sum17;
    assign sum17 = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = alu_en && ((alu_fun == 2'b00) ? sum17[16] :
                                  (alu_fun == 2'b01) ? (alu_a < alu_b) : 1'b0);
    always @(posedge clk) begin
        if (alu_en) begin
            case (alu_fun)
                2'b00: alu_out <= alu_a + alu_b;
                2'b01: alu_out <= alu_a - alu_b;
                2'b10: alu_out <= alu_a * alu_b;
                default: alu_out <= (alu_b == 16'd0) ? 16'hFFFF : alu_a / alu_b;
            endcase
        end
    end

    task automatic test_reset();
        async_rst = 1'b0;
        req_valid = 2'b11;
        #2;
        checks++;
        if ({req_ready, alu_en, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_carry, rsp_err, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b alu_en=%b rsp_valid=%b op_count=%0d, required all zero",
                     req_ready, alu_en, rsp_valid, op_count);
        end
        req_valid = 2'b00;
        @(negedge clk);
        async_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        req0_a = 16'h0003; req0_b = 16'h0004; req0_fun = 2'b00;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant: req_ready=%b required 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({alu_en, alu_a, alu_b, alu_fun, req_ready} !== {1'b1, 16'h0003, 16'h0004, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL add_issue: alu_en=%b a=%h b=%h fun=%b ready=%b required 1 0003 0004 00 00",
                     alu_en, alu_a, alu_b, alu_fun, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({alu_en, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL add_capture: alu_en=%b rsp_valid=%b required 0 00", alu_en, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== {2'b01, 16'h0007, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_resp: valid=%b data=%h carry=%b err=%b required 01 0007 0 0",
                     rsp_valid, rsp_data, rsp_carry, rsp_err);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if ({rsp_valid, op_count} !== {2'b00, 8'd1}) begin
            errors++; $display("FAIL add_handshake: valid=%b op_count=%0d required 00 1", rsp_valid, op_count);
        end
    endtask

    task automatic test_carry();
        req1_a = 16'hFFFF; req1_b = 16'h0001; req1_fun = 2'b00;
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== {2'b10, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_resp: valid=%b data=%h carry=%b err=%b required 10 0000 1 0",
                     rsp_valid, rsp_data, rsp_carry, rsp_err);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if (op_count !== 8'd2) begin errors++; $display("FAIL carry_count: op_count=%0d required 2", op_count); end
    endtask

    task automatic test_contention();
        int grants = 0;
        int resps = 0;
        logic [3:0] gseq = '0;
        async_rst = 1'b0;
        @(negedge clk);
        async_rst = 1'b1;
        req0_a = 16'd10; req0_b = 16'd3; req0_fun = 2'b01;
        req1_a = 16'd6;  req1_b = 16'd7; req1_fun = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int cyc = 0; cyc < 40 && resps < 4; cyc++) begin
            #1;
            if (req_ready != 2'b00 && grants < 4) begin
                gseq[grants] = req_ready[1];
                grants++;
            end
            if (rsp_valid != 2'b00) begin
                checks++;
                if (rsp_valid[1] ? (rsp_data !== 16'd42) : (rsp_data !== 16'd7)) begin
                    errors++; $display("FAIL contention_data: valid=%b data=%0d required 7 for req0, 42 for req1",
                                       rsp_valid, rsp_data);
                end
                resps++;
                if (resps == 4) req_valid = 2'b00;
            end
            @(negedge clk);
        end
        checks++;
        if (resps != 4 || grants != 4 || gseq !== 4'b1010) begin
            errors++; $display("FAIL contention_order: grants=%0d resps=%0d seq(lsb first)=%b required 4 4 1010",
                               grants, resps, gseq);
        end
        checks++;
        if (op_count !== 8'd4) begin errors++; $display("FAIL contention_count: op_count=%0d required 4", op_count); end
        rsp_ready = 2'b00;
    endtask

    task automatic test_div_zero();
        req0_a = 16'h0010; req0_b = 16'h0000; req0_fun = 2'b11;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL div0_grant: req_ready=%b required 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({alu_en, rsp_valid, rsp_data, rsp_carry, rsp_err} !== {1'b0, 2'b01, 16'hFFFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL div0_resp: alu_en=%b valid=%b data=%h carry=%b err=%b required 0 01 ffff 0 1",
                     alu_en, rsp_valid, rsp_data, rsp_carry, rsp_err);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if ({rsp_valid, op_count} !== {2'b00, 8'd5}) begin
            errors++; $display("FAIL div0_handshake: valid=%b op_count=%0d required 00 5", rsp_valid, op_count);
        end
    endtask

    task automatic test_backpressure_reset();
        bit seen = 1'b0;
        req1_a = 16'h1234; req1_b = 16'h1111; req1_fun = 2'b00;
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (rsp_valid != 2'b00) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_timeout: rsp_valid=%b never asserted, required 10", rsp_valid); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_carry, rsp_err, req_ready} !== {2'b10, 16'h2345, 1'b0, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold: valid=%b data=%h carry=%b err=%b ready=%b required 10 2345 0 0 00",
                         rsp_valid, rsp_data, rsp_carry, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        async_rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, alu_en, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_carry, rsp_err, op_count} !== '0) begin
            errors++;
            $display("FAIL midresp_reset: ready=%b alu_en=%b valid=%b data=%h op_count=%0d required all zero",
                     req_ready, alu_en, rsp_valid, rsp_data, op_count);
        end
        @(negedge clk);
        async_rst = 1'b1;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if ({req_ready, rsp_valid, op_count} !== {2'b01, 2'b00, 8'd0}) begin
            errors++; $display("FAIL post_reset_grant: ready=%b valid=%b op_count=%0d required 01 00 0",
                               req_ready, rsp_valid, op_count);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry();
        test_contention();
        test_div_zero();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
